// File: rtl/alu_ctrl_muldiv_pkg.sv
// rtl/alu_ctrl_muldiv_pkg.sv - shared ALUOp, ALUControl, OpCode and Funct encodings
package alu_ctrl_muldiv_pkg;

    localparam logic [1:0] ALUOP_LW_SW = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_NOR  = 4'b1100,
        ALU_XOR  = 4'b1101,
        ALU_NOP  = 4'b1111
    } alu_ctrl_e;

    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    typedef enum logic {S_IDLE, S_RUN} md_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_muldiv_iter.sv
// rtl/alu_ctrl_muldiv_muldiv_iter.sv - iterative multiply/divide unit with HI/LO registers
// Ports: start/op launch MULT(00) MULTU(01) DIV(10) DIVU(11); flush aborts a run;
// wr_hi/wr_lo load rs_val; busy/done/idle status; hi/lo architectural registers.
module muldiv_iter
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             idle,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc holds the partial product high half (mul) or partial remainder (div);
    // wq holds the multiplier being shifted out (mul) or the quotient being built (div).
    logic [WIDTH-1:0] acc_q, acc_d, wq_q, wq_d, mcand_q, mcand_d;
    logic             op_mul_q, op_mul_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] abs_rs, abs_rt;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, step_acc, step_wq, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        rs_neg    = ~op[0] & rs_val[WIDTH-1];
        rt_neg    = ~op[0] & rt_val[WIDTH-1];
        abs_rs    = rs_neg ? -rs_val : rs_val;
        abs_rt    = rt_neg ? -rt_val : rt_val;

        mul_sum   = {1'b0, acc_q} + ({(WIDTH+1){wq_q[0]}} & {1'b0, mcand_q});
        div_shift = {acc_q, wq_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        // Only consumed when div_ge, where the true difference fits in WIDTH bits.
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;

        step_acc  = op_mul_q ? mul_sum[WIDTH:1]
                             : (div_ge ? div_diff : div_shift[WIDTH-1:0]);
        step_wq   = op_mul_q ? {mul_sum[0], wq_q[WIDTH-1:1]}
                             : {wq_q[WIDTH-2:0], div_ge};

        prod      = {step_acc, step_wq};
        prod_fix  = neg_lo_q ? -prod : prod;
        res_hi    = op_mul_q ? prod_fix[2*WIDTH-1:WIDTH] : (neg_hi_q ? -step_acc : step_acc);
        res_lo    = op_mul_q ? prod_fix[WIDTH-1:0]       : (neg_lo_q ? -step_wq  : step_wq);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wq_d     = wq_q;
        mcand_d  = mcand_q;
        op_mul_d = op_mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = CNT_W'(WIDTH);
                    acc_d    = '0;
                    op_mul_d = ~op[1];
                    wq_d     = op[1] ? abs_rs : abs_rt;
                    mcand_d  = op[1] ? abs_rt : abs_rs;
                    // A zero divisor must leave the all-ones quotient uncorrected; the
                    // remainder then rebuilds the raw dividend after sign correction.
                    neg_lo_d = (rs_neg ^ rt_neg) & (~op[1] | (|rt_val));
                    neg_hi_d = rs_neg;
                end else begin
                    if (wr_hi) hi_d = rs_val;
                    if (wr_lo) lo_d = rs_val;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    wq_d  = step_wq;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            wq_q     <= '0;
            mcand_q  <= '0;
            op_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wq_q     <= wq_d;
            mcand_q  <= mcand_d;
            op_mul_q <= op_mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign idle = (state_q == S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - EX-stage ALU control decode with iterative mul/div and HI/LO
// Ports: ALUOp/OpCode/Funct decode to ALUControl and illegal; ex_valid/ex_flush qualify
// the EX instruction; rs_val/rt_val operands; md_stall/md_busy/md_done mul/div status;
// hilo_rdata returns HI or LO for MFHI/MFLO.
module alu_ctrl_muldiv
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ALUControl,
    output logic             illegal,
    output logic             md_stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hilo_rdata
);
    logic             matched;
    logic             md_req, md_fire, md_idle;
    logic [WIDTH-1:0] hi, lo;

    always_comb begin
        ALUControl = ALU_NOP;
        matched    = 1'b1;
        case (ALUOp)
            ALUOP_LW_SW: ALUControl = ALU_ADD;
            ALUOP_IMM: begin
                case (OpCode)
                    OP_ADDI, OP_ADDIU: ALUControl = ALU_ADD;
                    OP_SLTI:           ALUControl = ALU_SLT;
                    OP_SLTIU:          ALUControl = ALU_SLTU;
                    OP_ANDI:           ALUControl = ALU_AND;
                    OP_ORI:            ALUControl = ALU_OR;
                    OP_XORI:           ALUControl = ALU_XOR;
                    default:           matched    = 1'b0;
                endcase
            end
            ALUOP_RTYPE: begin
                case (Funct)
                    FN_SLL:           ALUControl = ALU_SLL;
                    FN_SRL:           ALUControl = ALU_SRL;
                    FN_SRA:           ALUControl = ALU_SRA;
                    FN_ADD, FN_ADDU:  ALUControl = ALU_ADD;
                    FN_SUB, FN_SUBU:  ALUControl = ALU_SUB;
                    FN_AND:           ALUControl = ALU_AND;
                    FN_OR:            ALUControl = ALU_OR;
                    FN_XOR:           ALUControl = ALU_XOR;
                    FN_NOR:           ALUControl = ALU_NOR;
                    FN_SLT:           ALUControl = ALU_SLT;
                    FN_SLTU:          ALUControl = ALU_SLTU;
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: ALUControl = ALU_NOP;
                    default:          matched    = 1'b0;
                endcase
            end
            default: matched = 1'b0;
        endcase
    end

    assign illegal  = ex_valid & ~matched;

    assign md_req   = ex_valid & (ALUOp == ALUOP_RTYPE) & is_md_funct(Funct) & ~ex_flush;
    assign md_stall = md_req & (md_busy | ~md_idle);
    assign md_fire  = md_req & ~md_stall;

    // Within the mul/div class, Funct[3] separates MULT..DIVU from the HI/LO moves,
    // and Funct[1:0] selects the specific operation.
    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_fire & Funct[3]),
        .op     (Funct[1:0]),
        .flush  (ex_flush),
        .wr_hi  (md_fire & (Funct == FN_MTHI)),
        .wr_lo  (md_fire & (Funct == FN_MTLO)),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (md_busy),
        .done   (md_done),
        .idle   (md_idle),
        .hi     (hi),
        .lo     (lo)
    );

    assign hilo_rdata = (md_fire && Funct == FN_MFHI) ? hi :
                        (md_fire && Funct == FN_MFLO) ? lo : '0;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb/tb_alu_ctrl_muldiv.sv - directed self-checking bench for alu_ctrl_muldiv
module tb_alu_ctrl_muldiv;
    logic        clk, rst_n;
    logic [1:0]  ALUOp;
    logic [5:0]  OpCode, Funct;
    logic        ex_valid, ex_flush;
    logic [31:0] rs_val, rt_val;
    logic [3:0]  ALUControl;
    logic        illegal, md_stall, md_busy, md_done;
    logic [31:0] hilo_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // {ALUOp, OpCode, Funct, illegal, ALUControl}
    logic [18:0] dec_tbl [0:31] = '{
        {2'b00, 6'd35, 6'd0,  1'b0, 4'h2},
        {2'b11, 6'd8,  6'd0,  1'b0, 4'h2}, {2'b11, 6'd9,  6'd0,  1'b0, 4'h2},
        {2'b11, 6'd10, 6'd0,  1'b0, 4'h7}, {2'b11, 6'd11, 6'd0,  1'b0, 4'h8},
        {2'b11, 6'd12, 6'd0,  1'b0, 4'h0}, {2'b11, 6'd13, 6'd0,  1'b0, 4'h1},
        {2'b11, 6'd14, 6'd0,  1'b0, 4'hD}, {2'b11, 6'd15, 6'd0,  1'b1, 4'hF},
        {2'b10, 6'd0,  6'd0,  1'b0, 4'h3}, {2'b10, 6'd0,  6'd2,  1'b0, 4'h4},
        {2'b10, 6'd0,  6'd3,  1'b0, 4'h5}, {2'b10, 6'd0,  6'd32, 1'b0, 4'h2},
        {2'b10, 6'd0,  6'd33, 1'b0, 4'h2}, {2'b10, 6'd0,  6'd34, 1'b0, 4'h6},
        {2'b10, 6'd0,  6'd35, 1'b0, 4'h6}, {2'b10, 6'd0,  6'd36, 1'b0, 4'h0},
        {2'b10, 6'd0,  6'd37, 1'b0, 4'h1}, {2'b10, 6'd0,  6'd38, 1'b0, 4'hD},
        {2'b10, 6'd0,  6'd39, 1'b0, 4'hC}, {2'b10, 6'd0,  6'd42, 1'b0, 4'h7},
        {2'b10, 6'd0,  6'd43, 1'b0, 4'h8},
        {2'b10, 6'd0,  6'd16, 1'b0, 4'hF}, {2'b10, 6'd0,  6'd17, 1'b0, 4'hF},
        {2'b10, 6'd0,  6'd18, 1'b0, 4'hF}, {2'b10, 6'd0,  6'd19, 1'b0, 4'hF},
        {2'b10, 6'd0,  6'd24, 1'b0, 4'hF}, {2'b10, 6'd0,  6'd25, 1'b0, 4'hF},
        {2'b10, 6'd0,  6'd26, 1'b0, 4'hF}, {2'b10, 6'd0,  6'd27, 1'b0, 4'hF},
        {2'b10, 6'd0,  6'd1,  1'b1, 4'hF}, {2'b01, 6'd0,  6'd32, 1'b1, 4'hF}
    };

    alu_ctrl_muldiv #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUOp      (ALUOp),
        .OpCode     (OpCode),
        .Funct      (Funct),
        .ex_valid   (ex_valid),
        .ex_flush   (ex_flush),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .md_stall   (md_stall),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .hilo_rdata (hilo_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_flush = 1'b0; ALUOp = 2'b00; OpCode = 6'd0; Funct = 6'd0;
        rs_val = 32'd0; rt_val = 32'd0;
    endtask

    task automatic drive_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1; ex_flush = 1'b0; ALUOp = 2'b10; OpCode = 6'd0; Funct = f;
        rs_val = a; rt_val = b;
    endtask

    task automatic read_reg(input string tag, input logic [5:0] f, input logic [31:0] exp);
        @(negedge clk);
        drive_r(f, 32'd0, 32'd0);
        #1;
        chk(tag, hilo_rdata, exp);
        idle_in();
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        @(negedge clk);
        drive_r(f, a, b);
        #1;
        chk({tag, " accept stall"}, {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        idle_in();
        for (int i = 0; i < 40; i++) begin
            if (md_busy) busy_cnt++;
            if (md_done) begin
                done_cnt++;
                done_at = i;
            end
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, busy_cnt, 32'd32);
        chk({tag, " done count"}, done_cnt, 32'd1);
        chk({tag, " done cycle"}, done_at, 32'd32);
        read_reg({tag, " HI"}, 6'd16, exp_hi);
        read_reg({tag, " LO"}, 6'd18, exp_lo);
    endtask

    initial begin
        int stall_cnt;
        int done_cnt;

        rst_n = 1'b1;
        idle_in();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", {31'd0, md_busy}, 32'd0);
        chk("reset done", {31'd0, md_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_reg("reset HI", 6'd16, 32'd0);
        read_reg("reset LO", 6'd18, 32'd0);

        // Decode sweep; flush keeps the mul/div class entries from launching anything.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ex_valid = 1'b1;
            ex_flush = 1'b1;
            {ALUOp, OpCode, Funct} = dec_tbl[i][18:5];
            #1;
            chk($sformatf("decode %0d", i), {27'd0, illegal, ALUControl}, {27'd0, dec_tbl[i][4:0]});
        end
        @(negedge clk);
        ex_valid = 1'b0; ex_flush = 1'b0; ALUOp = 2'b10; Funct = 6'd1;
        #1;
        chk("decode invalid slot", {27'd0, illegal, ALUControl}, {27'd0, 1'b0, 4'hF});
        idle_in();
        @(negedge clk);
        chk("sweep left unit idle", {31'd0, md_busy}, 32'd0);

        run_md("MULT",       6'd24, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md("MULTU",      6'd25, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB);
        run_md("DIVU",       6'd27, 32'd100,      32'd7,        32'd2,        32'd14);
        run_md("DIV neg",    6'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("DIV min",    6'd26, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_md("DIV by 0",   6'd26, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);

        // MFLO presented on the second cycle of a running multiply.
        @(negedge clk);
        drive_r(6'd25, 32'h12345678, 32'h10);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        drive_r(6'd18, 32'd0, 32'd0);
        stall_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!md_stall) break;
            stall_cnt++;
            @(negedge clk);
        end
        chk("MFLO stall cycles", stall_cnt, 32'd31);
        chk("MFLO after stall", hilo_rdata, 32'h23456780);
        idle_in();
        read_reg("MULTU stall HI", 6'd16, 32'd1);

        @(negedge clk);
        drive_r(6'd17, 32'h1234, 32'd0);
        @(negedge clk);
        idle_in();
        read_reg("MTHI", 6'd16, 32'h1234);
        @(negedge clk);
        drive_r(6'd19, 32'h5678, 32'd0);
        @(negedge clk);
        idle_in();
        read_reg("MTLO", 6'd18, 32'h5678);

        // Abort a DIV on its tenth busy cycle.
        @(negedge clk);
        drive_r(6'd26, 32'd100, 32'd7);
        @(negedge clk);
        idle_in();
        repeat (9) @(negedge clk);
        chk("flush busy before", {31'd0, md_busy}, 32'd1);
        ex_flush = 1'b1;
        @(negedge clk);
        ex_flush = 1'b0;
        chk("flush busy after", {31'd0, md_busy}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_done) done_cnt++;
            @(negedge clk);
        end
        chk("flush no done", done_cnt, 32'd0);
        read_reg("flush HI kept", 6'd16, 32'h1234);
        read_reg("flush LO kept", 6'd18, 32'h5678);

        @(negedge clk);
        drive_r(6'd24, 32'd3, 32'd3);
        ex_flush = 1'b1;
        @(negedge clk);
        idle_in();
        chk("flush at accept", {31'd0, md_busy}, 32'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        drive_r(6'd24, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        idle_in();
        repeat (5) @(negedge clk);
        chk("pre-reset busy", {31'd0, md_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", {31'd0, md_busy}, 32'd0);
        chk("mid reset done", {31'd0, md_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_reg("mid reset HI", 6'd16, 32'd0);
        read_reg("mid reset LO", 6'd18, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Execute-stage control block for the pipelined CPU. It decodes ALUOp, OpCode and Funct into the 4-bit ALUControl code, with an extended op set and an explicit illegal flag. It also hosts an iterative multiply/divide unit with architectural HI/LO registers, serving MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. A stall output holds the pipeline while a multiply or divide is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iterative latency equals WIDTH cycles
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ALUOp  in  2  00 LW_SW, 10 RTYPE, 11 IMM, 01 reserved
OpCode  in  6  instruction opcode
Funct  in  6  R-type function field
ex_valid  in  1  EX-stage instruction valid
ex_flush  in  1  kill EX instruction and abort any in-flight mul/div
rs_val  in  WIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source)
rt_val  in  WIDTH  rt operand (multiplier/divisor)
ALUControl  out  4  ALU operation code (combinational)
illegal  out  1  unmatched ALUOp/OpCode/Funct while ex_valid (combinational)
md_stall  out  1  hold IF/ID/EX (combinational)
md_busy  out  1  iteration in progress (registered)
md_done  out  1  one-cycle pulse on the cycle HI/LO take a mul/div result
hilo_rdata  out  WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: md_busy=0, md_done=0, HI=LO=0, counter=0, FSM=IDLE.
- ALUControl codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, SLTU 1000, NOR 1100, XOR 1101, NOP 1111.
- LW_SW -> ADD.
- IMM: ADDI(8)/ADDIU(9) -> ADD; SLTI(10) -> SLT; SLTIU(11) -> SLTU; ANDI(12) -> AND; ORI(13) -> OR; XORI(14) -> XOR.
- RTYPE funct: 0 SLL, 2 SRL, 3 SRA, 32/33 ADD, 34/35 SUB, 36 AND, 37 OR, 38 XOR, 39 NOR, 42 SLT, 43 SLTU.
- RTYPE funct 16-19 and 24-27 -> NOP (mul/div class).
- Any other combination -> NOP; illegal=ex_valid. Output is never latched; every path assigns.
- Mul/div class funct: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO.
- md_req = ex_valid & ALUOp==RTYPE & class funct & !ex_flush.
- FSM IDLE -> RUN: on md_req with MULT..DIVU while IDLE. Capture |rs|,|rt| (abs only for signed ops), the result sign and the remainder sign. Counter=WIDTH; md_busy=1 from next cycle.
- RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements.
- RUN -> IDLE: on the counter==1 step. Sign-correct and write HI/LO on that edge; md_done=1 for the following cycle.
- Total latency: accept at cycle T; HI/LO valid at T+WIDTH; md_busy high T+1..T+WIDTH.
- Results: MULT/MULTU give {HI,LO} = 2*WIDTH product. DIV/DIVU give LO=quotient, HI=remainder; the remainder takes the dividend's sign (truncating division).
- Divide by zero: same latency; LO=all ones, HI=rs_val (raw).
- Signed MIN / -1: LO=MIN, HI=0.
- md_stall = md_req & (md_busy | FSM!=IDLE), for any class funct. The stalled instruction re-presents; it is accepted on the first cycle the unit is IDLE.
- MTHI/MTLO, accepted while IDLE: write HI/LO on that edge.
- MFHI/MFLO: hilo_rdata is combinational when not stalled. A write and a read of the same register in the same cycle is impossible (single EX slot).
- ex_flush during RUN: return to IDLE next edge; HI/LO unchanged; no md_done.
- ex_flush in the accept cycle: nothing starts.
- rst_n low mid-operation: immediate return to the reset state.

Decomposition:
- Shared package: ALUOp encodings, ALUControl codes, OpCode and Funct constants (reused by the control unit and the ALU).
- One sub-module: muldiv_iter (FSM, counter, datapath, HI/LO).
- Decode stays in the top level.

Test Plan:
- Sweep every ALUOp/OpCode/Funct listed above -> codes exactly as tabulated. Funct 1 with ex_valid=1 -> 1111, illegal=1.
- MULT rs=-3 (FFFFFFFD), rt=7 -> md_busy 32 cycles, then HI=FFFFFFFF, LO=FFFFFFEB; md_done one cycle. MULTU same operands -> HI=00000006, LO=FFFFFFEB.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- DIV 5/0 -> after 32 cycles LO=FFFFFFFF, HI=00000005.
- MFLO issued 1 cycle after a MULT start -> md_stall high 31 cycles, then hilo_rdata = new LO. MTHI 1234 while idle -> HI=1234 next cycle.
- ex_flush at cycle 10 of a DIV -> md_busy low next cycle, HI/LO retain prior values, no md_done. rst_n pulse mid-MULT -> HI=LO=0, md_busy=0 immediately.
